// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core, with a retired-instruction counter.
// Optional: define ILLEGAL_OP_TRAP_EN to lock into a TRAP state on an unsupported opcode.
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             LessThan,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             pcw, irw, mw, rw, retire;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r,
                                            input logic f7b5);
    case (f3)
      3'b000:  alu_decode = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lt);
    case (f3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = !z;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      default: br_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcw        = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        irw       = mem_ready;
        pcw       = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, 1'b1, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0, funct7b5);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pcw        = br_taken(funct3, Zero, LessThan);
        state_d    = S_FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Only completed instructions count; a decode-time NOP returns from DECODE and is skipped.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

  // Strobes are masked by the asynchronous reset so an in-flight access is dropped at once.
  assign PCWrite  = pcw & reset;
  assign IRWrite  = irw & reset;
  assign MemWrite = mw  & reset;
  assign RegWrite = rw  & reset;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares. A 3-bit counter exercises instret wrap-around.
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, LessThan = 1'b0, mem_ready = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [CNT_W-1:0] instret;
  logic illegal;

  riscv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessThan(LessThan), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] ret;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  logic exp_ill = 1'b0;
  logic [1:0] imm = 2'b00;
  logic [15:0] act;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  function automatic logic [15:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm};
  endfunction

  function automatic logic [15:0] w_fetch(input logic rdy);
    return cw(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000);
  endfunction
  function automatic logic [15:0] w_dec();
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000);
  endfunction
  function automatic logic [15:0] w_memadr();
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000);
  endfunction
  function automatic logic [15:0] w_memrd();
    return cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [15:0] w_memwb();
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [15:0] w_memwr();
    return cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [15:0] w_execr(input logic [2:0] alu);
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu);
  endfunction
  function automatic logic [15:0] w_execi(input logic [2:0] alu);
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu);
  endfunction
  function automatic logic [15:0] w_aluwb();
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic logic [15:0] w_jal();
    return cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
  endfunction
  function automatic logic [15:0] w_br(input logic taken);
    return cw(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001);
  endfunction

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.ctrl || instret !== e.ret || illegal !== e.ill) begin
        errors++;
        $display("FAIL %s: got ctrl=%h instret=%0d illegal=%b, want ctrl=%h instret=%0d illegal=%b",
                 e.nm, act, instret, illegal, e.ctrl, e.ret, e.ill);
      end
    end
  end

  task automatic step(input string nm, input logic rdy, input logic [15:0] w);
    exp_t e;
    mem_ready = rdy;
    e.nm = nm; e.ctrl = w; e.ret = exp_ret; e.ill = exp_ill;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [1:0] im);
    op = o; funct3 = f3; funct7b5 = f7; imm = im;
  endtask

  task automatic run_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic is_r, input logic [2:0] alu);
    set_instr(o, f3, f7, 2'b00);
    step({nm, "_fetch"}, 1'b1, w_fetch(1'b1));
    step({nm, "_dec"}, 1'b1, w_dec());
    step({nm, "_exec"}, 1'b1, is_r ? w_execr(alu) : w_execi(alu));
    step({nm, "_wb"}, 1'b1, w_aluwb());
    exp_ret = exp_ret + CNT_W'(1);
  endtask

  task automatic run_br(input string nm, input logic [2:0] f3, input logic z,
                        input logic lt, input logic taken);
    set_instr(7'b1100011, f3, 1'b0, 2'b10);
    Zero = z; LessThan = lt;
    step({nm, "_fetch"}, 1'b1, w_fetch(1'b1));
    step({nm, "_dec"}, 1'b1, w_dec());
    step({nm, "_br"}, 1'b1, w_br(taken));
    exp_ret = exp_ret + CNT_W'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
    step("rst_hold", 1'b1, w_fetch(1'b0));
    reset = 1'b1;

    run_alu("add",  7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000);
    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 3'b001);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000);
    run_alu("slt",  7'b0110011, 3'b010, 1'b0, 1'b1, 3'b101);
    run_alu("ori",  7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011);
    run_alu("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 3'b010);
    run_alu("sll",  7'b0110011, 3'b001, 1'b0, 1'b1, 3'b000);

    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    step("sw_fetch", 1'b1, w_fetch(1'b1));
    step("sw_dec", 1'b1, w_dec());
    step("sw_adr", 1'b1, w_memadr());
    step("sw_wait0", 1'b0, w_memwr());
    step("sw_wait1", 1'b0, w_memwr());
    step("sw_wait2", 1'b0, w_memwr());
    step("sw_done", 1'b1, w_memwr());
    exp_ret = exp_ret + CNT_W'(1);

    run_br("bne_z1",  3'b001, 1'b1, 1'b0, 1'b0);
    run_br("bne_z0",  3'b001, 1'b0, 1'b0, 1'b1);
    run_br("bge_lt0", 3'b101, 1'b0, 1'b0, 1'b1);
    run_br("beq_z1",  3'b000, 1'b1, 1'b0, 1'b1);
    run_br("blt_lt1", 3'b100, 1'b0, 1'b1, 1'b1);
    run_br("bad_f3",  3'b010, 1'b1, 1'b1, 1'b0);

    set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    step("lw_fetch0", 1'b0, w_fetch(1'b0));
    step("lw_fetch1", 1'b0, w_fetch(1'b0));
    step("lw_fetch2", 1'b1, w_fetch(1'b1));
    step("lw_dec", 1'b1, w_dec());
    step("lw_adr", 1'b1, w_memadr());
    step("lw_rd_wait", 1'b0, w_memrd());
    step("lw_rd_done", 1'b1, w_memrd());
    step("lw_wb", 1'b1, w_memwb());
    exp_ret = exp_ret + CNT_W'(1);

    set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
    step("jal_fetch", 1'b1, w_fetch(1'b1));
    step("jal_dec", 1'b1, w_dec());
    step("jal_jal", 1'b1, w_jal());
    step("jal_wb", 1'b1, w_aluwb());
    exp_ret = exp_ret + CNT_W'(1);

    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    step("rsw_fetch", 1'b1, w_fetch(1'b1));
    step("rsw_dec", 1'b1, w_dec());
    step("rsw_adr", 1'b1, w_memadr());
    step("rsw_wait", 1'b0, w_memwr());
    reset = 1'b0;
    exp_ret = '0;
    step("rsw_async", 1'b1, w_fetch(1'b0));
    reset = 1'b1;
    run_alu("add_after_rst", 7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000);

    set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
    step("ill_fetch", 1'b1, w_fetch(1'b1));
    step("ill_dec", 1'b1, w_dec());
`ifdef ILLEGAL_OP_TRAP_EN
    exp_ill = 1'b1;
    for (int i = 0; i < 10; i++) step("trap_hold", 1'b1, 16'h0000);
    reset = 1'b0;
    exp_ill = 1'b0;
    exp_ret = '0;
    step("trap_rst", 1'b1, w_fetch(1'b0));
    reset = 1'b1;
`else
    step("nop_fetch", 1'b1, w_fetch(1'b1));
`endif

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
